// File: rtl/uart_fifo_core.sv
// Avalon-MM UART slave: TX/RX FIFOs, 16x oversampled receiver, optional parity,
// one or two stop bits, sticky error flags and a maskable level interrupt.
module uart_fifo_core #(
  parameter int unsigned DATA_BITS     = 8,
  parameter int unsigned FIFO_DEPTH    = 16,
  parameter int unsigned DIVISOR_RESET = 26
) (
  input  logic        clk_clk,
  input  logic        reset_reset,
  input  logic        uart_rxd,
  output logic        uart_txd,
  output logic        irq,
  input  logic [2:0]  s1_address,
  input  logic        s1_chipselect,
  input  logic        s1_read_n,
  input  logic        s1_write_n,
  input  logic [15:0] s1_writedata,
  output logic [15:0] s1_readdata
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(FIFO_DEPTH);
  localparam logic [3:0] LastBit = 4'(DATA_BITS - 1);

  typedef enum logic [2:0] {TxIdle, TxStart, TxData, TxParity, TxStop} tx_state_e;
  typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxParity, RxStop, RxWaitHigh} rx_state_e;

  // Bus decode
  logic rd_stb, wr_stb, rd_en;
  assign rd_stb = s1_chipselect & ~s1_read_n;
  assign wr_stb = s1_chipselect & ~s1_write_n;
  assign rd_en  = rd_stb & ~wr_stb;

  logic div_wr, ctrl_wr, stat_wr, tx_wr_req;
  assign div_wr    = wr_stb && (s1_address == 3'd4);
  assign ctrl_wr   = wr_stb && (s1_address == 3'd3);
  assign stat_wr   = wr_stb && (s1_address == 3'd2);
  assign tx_wr_req = wr_stb && (s1_address == 3'd1);

  logic [5:0]  ctrl_q;
  logic [15:0] div_q;
  logic [3:0]  flags_q, flags_d, flag_set, flag_clr;
  logic        irq_q;
  logic [15:0] rdata_q, rd_mux;

  // Baud tick generator
  logic [15:0] bcnt_q;
  logic        tick;
  assign tick = (bcnt_q == div_q);

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      bcnt_q <= '0;
    end else if (div_wr || tick) begin
      bcnt_q <= '0;
    end else begin
      bcnt_q <= bcnt_q + 16'd1;
    end
  end

  // TX FIFO
  logic [DATA_BITS-1:0] tx_mem [FIFO_DEPTH];
  logic [PtrW-1:0]      tx_wr_q, tx_rd_q;
  logic [CntW-1:0]      tx_cnt_q;
  logic                 tx_push, tx_pop, tx_empty, tx_full, tx_idle;
  logic [DATA_BITS-1:0] tx_head;

  assign tx_empty = (tx_cnt_q == '0);
  assign tx_full  = (tx_cnt_q == FullCnt);
  assign tx_push  = tx_wr_req && !tx_full;
  assign tx_head  = tx_mem[tx_rd_q];

  always_ff @(posedge clk_clk) begin
    if (tx_push) tx_mem[tx_wr_q] <= s1_writedata[DATA_BITS-1:0];
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      tx_wr_q  <= '0;
      tx_rd_q  <= '0;
      tx_cnt_q <= '0;
    end else begin
      if (tx_push) tx_wr_q <= tx_wr_q + PtrW'(1);
      if (tx_pop)  tx_rd_q <= tx_rd_q + PtrW'(1);
      case ({tx_push, tx_pop})
        2'b10:   tx_cnt_q <= tx_cnt_q + CntW'(1);
        2'b01:   tx_cnt_q <= tx_cnt_q - CntW'(1);
        default: tx_cnt_q <= tx_cnt_q;
      endcase
    end
  end

  // TX state machine; frames start on a tick so every bit is exactly 16 ticks
  tx_state_e            tx_state_q;
  logic [3:0]           tx_sub_q, tx_bit_q;
  logic [DATA_BITS-1:0] tx_shift_q;
  logic                 tx_par_q, tx_par_en_q, tx_two_stop_q, txd_q;
  logic                 tx_bit_end, tx_stop_done, tx_line;

  assign tx_bit_end   = tick && (tx_sub_q == 4'd15);
  assign tx_stop_done = (tx_state_q == TxStop) && tx_bit_end &&
                        (!tx_two_stop_q || (tx_bit_q != 4'd0));
  assign tx_pop       = !tx_empty && (((tx_state_q == TxIdle) && tick) || tx_stop_done);
  assign tx_idle      = tx_empty && (tx_state_q == TxIdle);

  always_comb begin
    tx_line = 1'b1;
    case (tx_state_q)
      TxStart:  tx_line = 1'b0;
      TxData:   tx_line = tx_shift_q[0];
      TxParity: tx_line = tx_par_q;
      default:  tx_line = 1'b1;
    endcase
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      tx_state_q    <= TxIdle;
      tx_sub_q      <= '0;
      tx_bit_q      <= '0;
      tx_shift_q    <= '0;
      tx_par_q      <= 1'b0;
      tx_par_en_q   <= 1'b0;
      tx_two_stop_q <= 1'b0;
      txd_q         <= 1'b1;
    end else begin
      txd_q <= tx_line;
      if (tick) tx_sub_q <= tx_sub_q + 4'd1;
      if (tx_pop) begin
        tx_state_q    <= TxStart;
        tx_sub_q      <= '0;
        tx_bit_q      <= '0;
        tx_shift_q    <= tx_head;
        tx_par_q      <= (^tx_head) ^ ctrl_q[4];
        tx_par_en_q   <= ctrl_q[3];
        tx_two_stop_q <= ctrl_q[5];
      end else if (tx_bit_end) begin
        unique case (tx_state_q)
          TxStart: begin
            tx_state_q <= TxData;
            tx_bit_q   <= '0;
          end
          TxData: begin
            tx_shift_q <= tx_shift_q >> 1;
            if (tx_bit_q == LastBit) begin
              tx_state_q <= tx_par_en_q ? TxParity : TxStop;
              tx_bit_q   <= '0;
            end else begin
              tx_bit_q <= tx_bit_q + 4'd1;
            end
          end
          TxParity: begin
            tx_state_q <= TxStop;
            tx_bit_q   <= '0;
          end
          TxStop: begin
            if (tx_stop_done) tx_state_q <= TxIdle;
            else              tx_bit_q   <= 4'd1;
          end
          default: tx_state_q <= TxIdle;
        endcase
      end
    end
  end

  assign uart_txd = txd_q;

  // RX synchroniser and state machine
  logic                 rx_s1_q, rx_s2_q, rx_prev_q;
  rx_state_e            rx_state_q;
  logic [3:0]           rx_sub_q, rx_bit_q;
  logic [DATA_BITS-1:0] rx_shift_q;
  logic                 rx_par_en_q, rx_par_odd_q, rx_par_bad_q;
  logic                 rx_sample, rx_push_req, rx_frm_set;

  assign rx_sample   = tick && ((rx_state_q == RxStart) ? (rx_sub_q == 4'd7)
                                                        : (rx_sub_q == 4'd15));
  assign rx_push_req = (rx_state_q == RxStop) && rx_sample && rx_s2_q;
  assign rx_frm_set  = (rx_state_q == RxStop) && rx_sample && !rx_s2_q;

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      rx_s1_q      <= 1'b1;
      rx_s2_q      <= 1'b1;
      rx_prev_q    <= 1'b1;
      rx_state_q   <= RxIdle;
      rx_sub_q     <= '0;
      rx_bit_q     <= '0;
      rx_shift_q   <= '0;
      rx_par_en_q  <= 1'b0;
      rx_par_odd_q <= 1'b0;
      rx_par_bad_q <= 1'b0;
    end else begin
      rx_s1_q   <= uart_rxd;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
      if (tick) rx_sub_q <= rx_sub_q + 4'd1;
      unique case (rx_state_q)
        RxIdle: begin
          if (rx_prev_q && !rx_s2_q) begin
            rx_state_q   <= RxStart;
            rx_sub_q     <= '0;
            rx_par_en_q  <= ctrl_q[3];
            rx_par_odd_q <= ctrl_q[4];
            rx_par_bad_q <= 1'b0;
          end
        end
        RxStart: begin
          if (rx_sample) begin
            if (rx_s2_q) begin
              rx_state_q <= RxIdle;
            end else begin
              rx_state_q <= RxData;
              rx_sub_q   <= '0;
              rx_bit_q   <= '0;
            end
          end
        end
        RxData: begin
          if (rx_sample) begin
            rx_shift_q <= {rx_s2_q, rx_shift_q[DATA_BITS-1:1]};
            if (rx_bit_q == LastBit) rx_state_q <= rx_par_en_q ? RxParity : RxStop;
            else                     rx_bit_q   <= rx_bit_q + 4'd1;
          end
        end
        RxParity: begin
          if (rx_sample) begin
            rx_par_bad_q <= rx_s2_q ^ (^rx_shift_q) ^ rx_par_odd_q;
            rx_state_q   <= RxStop;
          end
        end
        RxStop: begin
          if (rx_sample) rx_state_q <= rx_s2_q ? RxIdle : RxWaitHigh;
        end
        RxWaitHigh: begin
          if (rx_s2_q) rx_state_q <= RxIdle;
        end
        default: rx_state_q <= RxIdle;
      endcase
    end
  end

  // RX FIFO; a pop in the completing cycle frees room for the new character
  logic [DATA_BITS-1:0] rx_mem [FIFO_DEPTH];
  logic [PtrW-1:0]      rx_wr_q, rx_rd_q;
  logic [CntW-1:0]      rx_cnt_q;
  logic                 rx_push, rx_pop, rx_avail, rx_full;
  logic [DATA_BITS-1:0] rx_head;

  assign rx_avail = (rx_cnt_q != '0);
  assign rx_full  = (rx_cnt_q == FullCnt);
  assign rx_pop   = rd_en && (s1_address == 3'd0) && rx_avail;
  assign rx_push  = rx_push_req && (!rx_full || rx_pop);
  assign rx_head  = rx_mem[rx_rd_q];

  always_ff @(posedge clk_clk) begin
    if (rx_push) rx_mem[rx_wr_q] <= rx_shift_q;
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      rx_wr_q  <= '0;
      rx_rd_q  <= '0;
      rx_cnt_q <= '0;
    end else begin
      if (rx_push) rx_wr_q <= rx_wr_q + PtrW'(1);
      if (rx_pop)  rx_rd_q <= rx_rd_q + PtrW'(1);
      case ({rx_push, rx_pop})
        2'b10:   rx_cnt_q <= rx_cnt_q + CntW'(1);
        2'b01:   rx_cnt_q <= rx_cnt_q - CntW'(1);
        default: rx_cnt_q <= rx_cnt_q;
      endcase
    end
  end

  // Sticky flags {tx_ovf, par_err, frm_err, rx_ovr}; set beats write-1-to-clear
  always_comb begin
    flag_set = {tx_wr_req && tx_full, rx_push_req && rx_par_bad_q, rx_frm_set,
                rx_push_req && rx_full && !rx_pop};
    flag_clr = stat_wr ? s1_writedata[7:4] : 4'd0;
    flags_d  = (flags_q & ~flag_clr) | flag_set;
  end

  always_comb begin
    rd_mux = '0;
    case (s1_address)
      3'd0: if (rx_avail) rd_mux = 16'h8000 | 16'(rx_head);
      3'd2: rd_mux = {8'd0, flags_q, tx_idle, tx_empty, tx_full, rx_avail};
      3'd3: rd_mux = {10'd0, ctrl_q};
      3'd4: rd_mux = div_q;
      3'd5: rd_mux = {8'(tx_cnt_q), 8'(rx_cnt_q)};
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      ctrl_q  <= '0;
      div_q   <= 16'(DIVISOR_RESET);
      flags_q <= '0;
      irq_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      if (ctrl_wr) ctrl_q <= s1_writedata[5:0];
      if (div_wr)  div_q  <= s1_writedata;
      flags_q <= flags_d;
      irq_q   <= (ctrl_q[0] & rx_avail) | (ctrl_q[1] & tx_empty) | (ctrl_q[2] & (|flags_q));
      if (rd_stb) rdata_q <= wr_stb ? 16'd0 : rd_mux;
    end
  end

  assign irq         = irq_q;
  assign s1_readdata = rdata_q;

endmodule

// File: tb/tb_uart_fifo_core.sv
// Self-checking bench for uart_fifo_core: bus register checks, a serial TX monitor
// with a scoreboard, a serial RX driver, loopback, overflow and error-flag scenarios.
module tb_uart_fifo_core;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rxd, txd, irq;
  logic [2:0]  addr = 3'd0;
  logic        cs = 1'b0, rd_n = 1'b1, wr_n = 1'b1;
  logic [15:0] wdata = 16'd0, rdata;
  logic        loop = 1'b0, drv = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;
  int bit_clks = 16 * 27;
  logic mon_en = 1'b1, mon_par = 1'b0, mon_odd = 1'b0, mon_two = 1'b0;
  int tx_q[$];
  int rx_q[$];

  assign rxd = loop ? txd : drv;
  always #5 clk = ~clk;

  uart_fifo_core dut (
    .clk_clk       (clk),
    .reset_reset   (rst),
    .uart_rxd      (rxd),
    .uart_txd      (txd),
    .irq           (irq),
    .s1_address    (addr),
    .s1_chipselect (cs),
    .s1_read_n     (rd_n),
    .s1_write_n    (wr_n),
    .s1_writedata  (wdata),
    .s1_readdata   (rdata)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [15:0] d);
    @(negedge clk);
    addr = a; wdata = d; cs = 1'b1; wr_n = 1'b0;
    @(negedge clk);
    cs = 1'b0; wr_n = 1'b1;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [15:0] d);
    @(negedge clk);
    addr = a; cs = 1'b1; rd_n = 1'b0;
    @(negedge clk);
    cs = 1'b0; rd_n = 1'b1;
    d = rdata;
  endtask

  task automatic read_check(input string tag, input logic [2:0] a, input logic [15:0] exp);
    logic [15:0] d;
    bus_read(a, d);
    check(tag, d, exp);
  endtask

  task automatic read_rx(input string tag);
    logic [15:0] d;
    int exp;
    exp = (rx_q.size() != 0) ? rx_q.pop_front() : 32'hDEAD;
    bus_read(3'd0, d);
    check(tag, d, exp);
  endtask

  // Serial 8N1 frame into uart_rxd with a selectable stop-bit level
  task automatic send_rx(input logic [7:0] d, input logic stop_v);
    drv = 1'b0;
    repeat (bit_clks) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      drv = d[i];
      repeat (bit_clks) @(negedge clk);
    end
    drv = stop_v;
    repeat (bit_clks) @(negedge clk);
    drv = 1'b1;
    repeat (bit_clks) @(negedge clk);
  endtask

  task automatic wait_tx_done(input int max_clks);
    int c = 0;
    while (tx_q.size() != 0 && c < max_clks) begin
      @(negedge clk);
      c++;
    end
    check("tx_drain", tx_q.size(), 0);
  endtask

  task automatic measure_run(input logic lvl, output int n);
    n = 0;
    while (txd === lvl && n < 2000) begin
      n++;
      @(negedge clk);
    end
  endtask

  // TX line monitor: decodes frames at bit centres and pops the TX scoreboard
  logic [7:0] md;
  initial begin
    forever begin
      @(negedge txd);
      if (mon_en) begin
        repeat (bit_clks / 2) @(negedge clk);
        check("mon_start", txd, 1'b0);
        for (int i = 0; i < 8; i++) begin
          repeat (bit_clks) @(negedge clk);
          md[i] = txd;
        end
        if (mon_par) begin
          repeat (bit_clks) @(negedge clk);
          check("mon_parity", txd, (^md) ^ mon_odd);
        end
        repeat (bit_clks) @(negedge clk);
        check("mon_stop1", txd, 1'b1);
        if (mon_two) begin
          repeat (bit_clks) @(negedge clk);
          check("mon_stop2", txd, 1'b1);
        end
        check("tx_char", md, (tx_q.size() != 0) ? tx_q.pop_front() : 32'h100);
      end
    end
  end

  initial begin
    logic [15:0] r;
    logic [7:0]  b;
    int k, n;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_txd", txd, 1'b1);
    check("rst_irq", irq, 1'b0);
    check("rst_rdata", rdata, 16'h0000);
    rst = 1'b0;
    read_check("rst_status", 3'd2, 16'h000C);
    read_check("rst_control", 3'd3, 16'h0000);
    read_check("rst_divisor", 3'd4, 16'd26);
    read_check("rst_level", 3'd5, 16'h0000);
    read_check("rx_empty_read", 3'd0, 16'h0000);
    read_check("addr6_read", 3'd6, 16'h0000);

    // Simultaneous read and write: write lands, read returns 0
    @(negedge clk);
    addr = 3'd3; wdata = 16'h0002; cs = 1'b1; rd_n = 1'b0; wr_n = 1'b0;
    @(negedge clk);
    cs = 1'b0; rd_n = 1'b1; wr_n = 1'b1;
    check("rw_rdata", rdata, 16'h0000);
    repeat (2) @(negedge clk);
    check("irq_tx_ie", irq, 1'b1);
    read_check("rw_control", 3'd3, 16'h0002);
    bus_write(3'd3, 16'h0000);
    repeat (2) @(negedge clk);
    check("irq_off", irq, 1'b0);

    // 8N1 transmit of 0x55 at DIVISOR=3: exact bit widths
    bus_write(3'd4, 16'd3);
    bit_clks = 64;
    b = 8'h55;
    bus_write(3'd1, 16'h0055);
    tx_q.push_back(8'h55);
    k = 0;
    while (txd === 1'b1 && k < 1000) begin
      @(negedge clk);
      k++;
    end
    check("tx_latency_ok", (k >= 2 && k <= 6), 1'b1);
    measure_run(1'b0, n);
    check("start_len", n, 64);
    for (int i = 0; i < 8; i++) begin
      measure_run(b[i], n);
      check("data_bit_len", n, 64);
    end
    repeat (70) @(negedge clk);
    check("stop_txd", txd, 1'b1);
    read_check("tx_idle_status", 3'd2, 16'h000C);
    wait_tx_done(200);

    // Loopback with odd parity and two stop bits
    bus_write(3'd3, 16'h0038);
    mon_par = 1'b1; mon_odd = 1'b1; mon_two = 1'b1;
    loop = 1'b1;
    foreach (b[i]) begin end
    bus_write(3'd1, 16'h0000); tx_q.push_back(8'h00); rx_q.push_back(32'h8000);
    bus_write(3'd1, 16'h00FF); tx_q.push_back(8'hFF); rx_q.push_back(32'h80FF);
    bus_write(3'd1, 16'h00A5); tx_q.push_back(8'hA5); rx_q.push_back(32'h80A5);
    wait_tx_done(5000);
    repeat (200) @(negedge clk);
    for (int i = 0; i < 3; i++) read_rx("loop_rxdata");
    read_check("loop_status", 3'd2, 16'h000C);
    loop = 1'b0;
    mon_par = 1'b0; mon_odd = 1'b0; mon_two = 1'b0;
    bus_write(3'd3, 16'h0000);

    // TX overflow with a stalled baud tick
    bus_write(3'd4, 16'd1000);
    for (int i = 0; i < 17; i++) begin
      bus_write(3'd1, 16'(32'h30 + i));
      if (i < 16) tx_q.push_back(32'h30 + i);
    end
    read_check("txovf_status", 3'd2, 16'h0082);
    read_check("txovf_level", 3'd5, 16'h1000);
    bus_write(3'd4, 16'd3);
    wait_tx_done(25000);
    repeat (100) @(negedge clk);
    bus_write(3'd2, 16'h0080);
    read_check("txovf_cleared", 3'd2, 16'h000C);

    // Framing error with err_ie
    bus_write(3'd3, 16'h0004);
    send_rx(8'h3C, 1'b0);
    read_check("frm_status", 3'd2, 16'h002C);
    read_check("frm_level", 3'd5, 16'h0000);
    check("frm_irq", irq, 1'b1);
    bus_write(3'd2, 16'h0020);
    repeat (2) @(negedge clk);
    check("frm_irq_clr", irq, 1'b0);
    read_check("frm_cleared", 3'd2, 16'h000C);
    bus_write(3'd3, 16'h0000);

    // RX overrun: 17 characters, no reads
    for (int i = 0; i < 17; i++) begin
      send_rx(8'(32'h10 + i), 1'b1);
      if (i < 16) rx_q.push_back(32'h8010 + i);
    end
    read_check("ovr_status", 3'd2, 16'h001D);
    read_check("ovr_level", 3'd5, 16'h0010);
    for (int i = 0; i < 16; i++) read_rx("ovr_rxdata");
    read_check("ovr_17th_absent", 3'd0, 16'h0000);
    bus_write(3'd2, 16'h00F0);
    read_check("ovr_cleared", 3'd2, 16'h000C);

    // Short low glitch is a false start
    drv = 1'b0;
    repeat (16) @(negedge clk);
    drv = 1'b1;
    repeat (3 * 64) @(negedge clk);
    read_check("glitch_level", 3'd5, 16'h0000);
    read_check("glitch_status", 3'd2, 16'h000C);

    // Reset mid-frame forces the line high without a clock edge
    mon_en = 1'b0;
    bus_write(3'd1, 16'h00A0);
    k = 0;
    while (txd === 1'b1 && k < 1000) begin
      @(negedge clk);
      k++;
    end
    check("pre_rst_txd", txd, 1'b0);
    #2 rst = 1'b1;
    #1 check("async_rst_txd", txd, 1'b1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    read_check("post_rst_level", 3'd5, 16'h0000);
    read_check("post_rst_status", 3'd2, 16'h000C);
    read_check("post_rst_divisor", 3'd4, 16'd26);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_fifo_core.md
# uart_fifo_core

Parametrised Avalon-MM UART with transmit and receive FIFOs, a programmable baud divisor, and 16x receive oversampling. It supports optional parity and one or two stop bits, keeps sticky error flags, and raises a maskable interrupt. It sits on the monitor FPGA system bus as a slave and drives the external serial pins.

## Interface
Parameters:
- DATA_BITS, 8: character width, legal range 5..9.
- FIFO_DEPTH, 16: entries per FIFO; power of two, 2..128.
- DIVISOR_RESET, 26: reset value of the DIVISOR register.

Ports:
- clk_clk  in  1  single system clock.
- reset_reset  in  1  asynchronous, active-high reset.
- uart_rxd  in  1  serial input; asynchronous; idle high.
- uart_txd  out  1  serial output; idle high.
- irq  out  1  level interrupt, registered.
- s1_address  in  3  word address.
- s1_chipselect  in  1  slave select.
- s1_read_n  in  1  active-low read strobe.
- s1_write_n  in  1  active-low write strobe.
- s1_writedata  in  16  write data.
- s1_readdata  out  16  read data; read latency 1.

## Operation
- Strobes:
  - Read strobe = chipselect & ~read_n.
  - Write strobe = chipselect & ~write_n.
  - Both strobes asserted in the same cycle: the write is performed and the read returns 0.
- Register map:
  - 0 RXDATA (R): [DATA_BITS-1:0] is the head of the RX FIFO; bit15 = FIFO was non-empty. A read pops the FIFO. Reading an empty FIFO returns 0 and pops nothing.
  - 1 TXDATA (W): pushes [DATA_BITS-1:0]. If the TX FIFO is full, the data is dropped and tx_ovf is set.
  - 2 STATUS: bit0 rx_avail, bit1 tx_full, bit2 tx_empty, bit3 tx_idle (FIFO empty and shifter idle), bit4 rx_ovr, bit5 frm_err, bit6 par_err, bit7 tx_ovf.
    - Bits 4..7 are sticky; writing 1 to a bit clears it.
    - A set event in the same cycle as a clear wins.
  - 3 CONTROL (R/W, reset 0): bit0 rx_ie, bit1 tx_ie, bit2 err_ie, bit3 par_en, bit4 par_odd, bit5 two_stop.
  - 4 DIVISOR (R/W, 16 bit).
  - 5 LEVEL (R): [7:0] RX count, [15:8] TX count.
  - 6, 7: read 0; writes ignored.
- Baud tick:
  - A counter counts 0..DIVISOR; a one-cycle tick is issued at DIVISOR, then the counter returns to 0.
  - One bit time = 16 ticks = 16*(DIVISOR+1) clocks.
  - Any DIVISOR write zeroes the counter.
- TX state machine, states IDLE -> START -> DATA -> PARITY -> STOP -> IDLE:
  - Leaves IDLE when the FIFO is non-empty; the entry is popped at that point.
  - par_en, par_odd and two_stop are latched at the pop; CONTROL changes mid-frame take effect on the next frame.
  - Data is sent LSB first.
  - PARITY is skipped when par_en = 0.
  - STOP lasts 1 or 2 bit times.
  - Back-to-back frames have no idle gap.
- RX path:
  - Two-flop synchroniser on uart_rxd.
  - States IDLE -> START -> DATA -> PARITY -> STOP.
  - A falling edge in IDLE starts START. After 8 ticks the line is resampled; if it is high, this is a false start and RX returns to IDLE.
  - Each following bit is sampled 16 ticks after the previous sample.
  - Stop bit sampled low: the character is discarded, frm_err is set, and RX enters WAIT_HIGH until the line is high, then returns to IDLE.
  - Parity mismatch: the character is stored and par_err is set.
  - Character completes while the RX FIFO is full: it is dropped and rx_ovr is set, unless a pop occurs in the same cycle, in which case the push is accepted.
- irq (registered) = (rx_ie & rx_avail) | (tx_ie & tx_empty) | (err_ie & (rx_ovr|frm_err|par_err|tx_ovf)).

## Timing
- Reset values:
  - uart_txd = 1, irq = 0, s1_readdata = 0.
  - Both FIFOs empty, all flags 0, CONTROL = 0, DIVISOR = DIVISOR_RESET.
  - Both state machines in IDLE; tick counter at 0.
- Reset asserted mid-frame: uart_txd goes to 1 immediately (asynchronously); any partial character is lost.
- s1_readdata is valid one clock after the read strobe. It holds that value until the next read strobe.
- A RXDATA pop and any STATUS/LEVEL change it causes are visible one cycle after the read strobe.
- TXDATA write to idle TX: the uart_txd start-bit falling edge appears no earlier than 2 and no later than DIVISOR+3 clocks after the write strobe.
- FIFO counts range from 0 to FIFO_DEPTH. A simultaneous push and pop leaves the count unchanged. Pointers wrap modulo FIFO_DEPTH.
- irq changes exactly one cycle after its source condition changes.

## Test plan
- DIVISOR = 3, write TXDATA 0x55, 8N1 -> uart_txd: 64 clocks low, then 0x55 LSB first, then 64 clocks high. STATUS tx_idle = 1 after the stop bit completes.
- Loop uart_txd to uart_rxd with par_en = 1, par_odd = 1, two_stop = 1; send 0x00, 0xFF, 0xA5 -> RXDATA returns 0x8000, 0x80FF, 0x80A5. No error flags set.
- Write 17 characters with FIFO_DEPTH = 16 while TX is stalled by a large DIVISOR -> tx_ovf = 1, LEVEL[15:8] = 16. The first 16 characters are transmitted in order.
- Drive stop bit = 0 on 0x3C -> frm_err = 1, nothing stored. With err_ie = 1, irq = 1; after writing STATUS 0x0020, irq = 0.
- Receive 17 characters without reading -> rx_ovr = 1, LEVEL[7:0] = 16, and the 17th character is absent.
- A 4-tick low glitch on uart_rxd -> false start; no character stored; no flags set.
